naive_cpu: RTL and testbench
============================

// Module: naive_cpu
// PURPOSE
//  Minimal 5-stage in-order pipelined CPU core (IF, ID, EX, MEM, WB).
//  - 16-bit instructions fetched from an external combinational ROM; 16 x 16-bit register file.
//  - Read-only debug observer port exposes registers and pipeline state.
//  - Top-level core of the design; no data memory (MEM stage is pass-through).
// PARAMETERS
//  RESET_PC  16'h0000  PC value loaded on reset; first fetch address.
// PORTS
//  clk         in   1   single clock, rising edge
//  rst         in   1   asynchronous, active-low reset
//  rom_data_i  in   16  instruction at rom_addr_o (combinational ROM)
//  rom_addr_o  out  16  fetch address (= PC, word address)
//  rom_ce_o    out  1   ROM chip enable; 1 = fetch valid
//  ob_sel      in   4   observer register select
//  ob_mode_i   in   3   observer mode select
//  ob_data_o   out  16  observer data (combinational)
// BEHAVIOUR
//  Reset (rst=0, async):
//  - PC=RESET_PC, rom_ce_o=0.
//  - All pipeline registers cleared, write-enables 0.
//  - All GPRs = 0.
//  Fetch:
//  - rom_ce_o goes 1 on first rising edge after rst=1.
//  - PC holds while rom_ce_o=0; else PC+=1 each cycle, FFFF wraps to 0000.
//  - IF/ID latches rom_data_i when rom_ce_o=1, else loads bubble (we=0).
//  Encoding, all ops read-modify-write rd (rd = rd OP x):
//  - op[15:10], rd[9:6], imm6[5:0]; R-type adds rs[5:2], fn[1:0].
//  - 000000 R-type: fn 00 ADD rd+rs, 01 SUB rd-rs, 10 AND, 11 OR.
//  - 001000 ADDI rd+sext(imm6).
//  - 001100 ANDI, 001101 ORI, 001110 XORI: rd OP zext(imm6).
//  - 001111 LUI rd = {imm6,10'b0}.
//  - Any other opcode = NOP, no write.
//  Datapath:
//  - Arithmetic mod 2^16, no flags or traps.
//  - r0 reads 0; writes to r0 dropped.
//  - No branches, no stalls, no flushes.
//  Regfile:
//  - Written on rising edge from MEM/WB.
//  - Same-cycle read of the address being written returns new data (write-through).
//  Latency: instruction presented on rom_data_i at edge N is written at edge N+4, visible via observer after it.
//  Observer ob_mode_i:
//  - 0: GPR[ob_sel].
//  - 1: PC.
//  - 2: IF/ID instruction.
//  - 3: EX ALU result.
//  - 4: WB write data.
//  - 5: {wb_we,11'b0,wb_waddr}.
//  - 6,7: 16'h0000.
//  - Reset mid-run: pipeline contents discarded, state as above.
// CONFIGURATION
//  FORWARDING_EN defined:
//  - ID operands bypassed from EX, MEM, WB results, priority EX > MEM > WB.
//  - Back-to-back dependent instructions correct.
//  FORWARDING_EN undefined:
//  - No bypass beyond regfile write-through; software inserts 2 independent ops between producer and consumer.
//  - Stale operands otherwise; no hardware interlock.
// TESTING
//  1. rst=0 40ns, then release.
//     - During reset: rom_ce_o=0, rom_addr_o=0000, ob mode 0 all regs = 0.
//     - After release: PC increments 1/cycle.
//  2. rom_data_i held 16'h3443 (ORI r1,3), ob_mode=0, ob_sel=1 -> r1 reads 0003 from 4th edge after first fetch, stays 0003.
//  3. Stream:
//     - ADDI r2,1 (16'h2081) repeated, FORWARDING_EN -> r2 increments 1 per cycle once WB starts.
//     - Without FORWARDING_EN, increments by 1 every 3 cycles.
//  4. Stream:
//     - LUI r3,0x3F, then ADD r3,r3 -> r3 = FC00 then F800 (wrap check).
//     - Writes to r0 -> r0 stays 0000.
//  5. Observer: mode 1 tracks PC; mode 2 shows last fetched instruction; mode 6/7 -> 0000.

Source files
------------

// File: rtl/naive_cpu.sv
// Five-stage in-order core (IF, ID, EX, MEM, WB) with a read-only observer port.
// Define FORWARDING_EN to bypass EX/MEM/WB results into ID operands.
module naive_cpu #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] rom_data_i,
  output logic [15:0] rom_addr_o,
  output logic        rom_ce_o,
  input  logic [3:0]  ob_sel,
  input  logic [2:0]  ob_mode_i,
  output logic [15:0] ob_data_o
);

  typedef enum logic [2:0] {
    ALU_ADD  = 3'd0,
    ALU_SUB  = 3'd1,
    ALU_AND  = 3'd2,
    ALU_OR   = 3'd3,
    ALU_XOR  = 3'd4,
    ALU_PASS = 3'd5
  } alu_op_t;

  logic [15:0] pc;
  logic        fetch_en;

  logic [15:0] ifid_instr;
  logic        ifid_valid;

  logic [15:0] idex_a;
  logic [15:0] idex_b;
  alu_op_t     idex_op;
  logic [3:0]  idex_rd;
  logic        idex_we;

  logic [15:0] exmem_data;
  logic [3:0]  exmem_rd;
  logic        exmem_we;

  logic [15:0] wb_data;
  logic [3:0]  wb_waddr;
  logic        wb_we;

  logic [15:0] gpr [16];

  // Fetch: the first edge after reset only enables the ROM; PC starts moving next edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_en <= 1'b0;
      pc       <= RESET_PC;
    end else begin
      fetch_en <= 1'b1;
      if (fetch_en) pc <= pc + 16'd1;
    end
  end

  assign rom_addr_o = pc;
  assign rom_ce_o   = fetch_en;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ifid_instr <= '0;
      ifid_valid <= 1'b0;
    end else if (fetch_en) begin
      ifid_instr <= rom_data_i;
      ifid_valid <= 1'b1;
    end else begin
      ifid_instr <= '0;
      ifid_valid <= 1'b0;
    end
  end

  logic [5:0] id_opc;
  logic [3:0] id_rd;
  logic [3:0] id_rs;
  logic [1:0] id_fn;
  logic [5:0] id_imm;

  assign id_opc = ifid_instr[15:10];
  assign id_rd  = ifid_instr[9:6];
  assign id_rs  = ifid_instr[5:2];
  assign id_fn  = ifid_instr[1:0];
  assign id_imm = ifid_instr[5:0];

  alu_op_t     dec_op;
  logic        dec_we;
  logic        dec_use_imm;
  logic [15:0] dec_imm;

  always_comb begin
    dec_op      = ALU_ADD;
    dec_we      = 1'b0;
    dec_use_imm = 1'b0;
    dec_imm     = '0;
    if (ifid_valid) begin
      case (id_opc)
        6'b000000: begin
          dec_we = 1'b1;
          case (id_fn)
            2'b00:   dec_op = ALU_ADD;
            2'b01:   dec_op = ALU_SUB;
            2'b10:   dec_op = ALU_AND;
            default: dec_op = ALU_OR;
          endcase
        end
        6'b001000: begin
          dec_we = 1'b1; dec_use_imm = 1'b1; dec_op = ALU_ADD;
          dec_imm = {{10{id_imm[5]}}, id_imm};
        end
        6'b001100: begin
          dec_we = 1'b1; dec_use_imm = 1'b1; dec_op = ALU_AND;
          dec_imm = {10'b0, id_imm};
        end
        6'b001101: begin
          dec_we = 1'b1; dec_use_imm = 1'b1; dec_op = ALU_OR;
          dec_imm = {10'b0, id_imm};
        end
        6'b001110: begin
          dec_we = 1'b1; dec_use_imm = 1'b1; dec_op = ALU_XOR;
          dec_imm = {10'b0, id_imm};
        end
        6'b001111: begin
          dec_we = 1'b1; dec_use_imm = 1'b1; dec_op = ALU_PASS;
          dec_imm = {id_imm, 10'b0};
        end
        default: dec_we = 1'b0;
      endcase
    end
    // r0 is hardwired to zero, so a write to it is simply never issued.
    if (id_rd == 4'd0) dec_we = 1'b0;
  end

  // Register-file read ports with write-through from the WB stage.
  logic [15:0] rf_a;
  logic [15:0] rf_b;

  always_comb begin
    rf_a = gpr[id_rd];
    if (wb_we && (wb_waddr == id_rd)) rf_a = wb_data;
    if (id_rd == 4'd0) rf_a = '0;
    rf_b = gpr[id_rs];
    if (wb_we && (wb_waddr == id_rs)) rf_b = wb_data;
    if (id_rs == 4'd0) rf_b = '0;
  end

  logic [15:0] ex_result;
  logic [15:0] op_a;
  logic [15:0] op_b;

`ifdef FORWARDING_EN
  // Later assignments win, giving EX > MEM > WB (WB already folded into rf_*).
  always_comb begin
    op_a = rf_a;
    op_b = rf_b;
    if (exmem_we && (exmem_rd == id_rd)) op_a = exmem_data;
    if (exmem_we && (exmem_rd == id_rs)) op_b = exmem_data;
    if (idex_we && (idex_rd == id_rd))   op_a = ex_result;
    if (idex_we && (idex_rd == id_rs))   op_b = ex_result;
  end
`else
  assign op_a = rf_a;
  assign op_b = rf_b;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idex_a  <= '0;
      idex_b  <= '0;
      idex_op <= ALU_ADD;
      idex_rd <= '0;
      idex_we <= 1'b0;
    end else begin
      idex_a  <= op_a;
      idex_b  <= dec_use_imm ? dec_imm : op_b;
      idex_op <= dec_op;
      idex_rd <= id_rd;
      idex_we <= dec_we;
    end
  end

  always_comb begin
    case (idex_op)
      ALU_ADD:  ex_result = idex_a + idex_b;
      ALU_SUB:  ex_result = idex_a - idex_b;
      ALU_AND:  ex_result = idex_a & idex_b;
      ALU_OR:   ex_result = idex_a | idex_b;
      ALU_XOR:  ex_result = idex_a ^ idex_b;
      ALU_PASS: ex_result = idex_b;
      default:  ex_result = '0;
    endcase
  end

  // MEM has no data memory; EX/MEM and MEM/WB are plain pass-through registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      exmem_data <= '0;
      exmem_rd   <= '0;
      exmem_we   <= 1'b0;
      wb_data    <= '0;
      wb_waddr   <= '0;
      wb_we      <= 1'b0;
    end else begin
      exmem_data <= ex_result;
      exmem_rd   <= idex_rd;
      exmem_we   <= idex_we;
      wb_data    <= exmem_data;
      wb_waddr   <= exmem_rd;
      wb_we      <= exmem_we;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 16; i++) gpr[i] <= '0;
    end else if (wb_we && (wb_waddr != 4'd0)) begin
      gpr[wb_waddr] <= wb_data;
    end
  end

  always_comb begin
    case (ob_mode_i)
      3'd0:    ob_data_o = gpr[ob_sel];
      3'd1:    ob_data_o = pc;
      3'd2:    ob_data_o = ifid_instr;
      3'd3:    ob_data_o = ex_result;
      3'd4:    ob_data_o = wb_data;
      3'd5:    ob_data_o = {wb_we, 11'b0, wb_waddr};
      default: ob_data_o = '0;
    endcase
  end

endmodule

// File: tb/tb_naive_cpu.sv
// Directed bench for naive_cpu: reset state, fetch/PC, latency, ADDI stream, ALU program.
`timescale 1ns/1ps
module tb_naive_cpu;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] rom_data_i;
  logic [15:0] rom_addr_o;
  logic        rom_ce_o;
  logic [3:0]  ob_sel;
  logic [2:0]  ob_mode_i;
  logic [15:0] ob_data_o;

  logic [15:0] rom [64];
  logic [15:0] exp_q [$];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    int          cyc;
    logic [2:0]  mode;
    logic [3:0]  sel;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs [$];

  assign rom_data_i = rom[rom_addr_o[5:0]];

  always #50 clk = ~clk;

  naive_cpu #(.RESET_PC(16'h0000)) dut (
    .clk        (clk),
    .rst        (rst),
    .rom_data_i (rom_data_i),
    .rom_addr_o (rom_addr_o),
    .rom_ce_o   (rom_ce_o),
    .ob_sel     (ob_sel),
    .ob_mode_i  (ob_mode_i),
    .ob_data_o  (ob_data_o)
  );

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic observe(input logic [2:0] mode, input logic [3:0] sel, output logic [15:0] val);
    ob_mode_i = mode;
    ob_sel    = sel;
    #1;
    val = ob_data_o;
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
    cyc++;
  endtask

  task automatic add_vec(input int c, input logic [2:0] m, input logic [3:0] s, input logic [15:0] e);
    vec_t v;
    v.cyc = c; v.mode = m; v.sel = s; v.exp = e;
    vecs.push_back(v);
  endtask

  // Drops rst asynchronously, checks the cleared state, then releases ~40ns later.
  task automatic apply_reset(input logic [15:0] fill);
    logic [15:0] v;
    rst = 1'b0;
    for (int i = 0; i < 64; i++) rom[i] = fill;
    #1;
    check("rst_ce", {15'b0, rom_ce_o}, 16'h0000);
    check("rst_addr", rom_addr_o, 16'h0000);
    for (int r = 0; r < 16; r++) begin
      observe(3'd0, r[3:0], v);
      check($sformatf("rst_r%0d", r), v, 16'h0000);
    end
    observe(3'd2, 4'd0, v);
    check("rst_ifid", v, 16'h0000);
    observe(3'd5, 4'd0, v);
    check("rst_wbctl", v, 16'h0000);
    #20;
    rst = 1'b1;
    cyc = 0;
  endtask

  initial begin
    logic [15:0] v;
    logic [15:0] e;
    ob_sel    = '0;
    ob_mode_i = '0;
    rst       = 1'b1;
    #1;

    // ORI r1,3 held on the ROM bus.
    apply_reset(16'h3443);
    for (int k = 1; k <= 10; k++) begin
      tick();
      check($sformatf("a_ce_e%0d", k), {15'b0, rom_ce_o}, 16'h0001);
      check($sformatf("a_addr_e%0d", k), rom_addr_o, 16'(k - 1));
      observe(3'd1, 4'd0, v);
      check($sformatf("a_pc_e%0d", k), v, 16'(k - 1));
      observe(3'd0, 4'd1, v);
      check($sformatf("a_r1_e%0d", k), v, (k >= 6) ? 16'h0003 : 16'h0000);
      if (k == 2) begin
        observe(3'd2, 4'd0, v);
        check("a_ifid_e2", v, 16'h3443);
      end
    end
    observe(3'd6, 4'd1, v);
    check("a_mode6", v, 16'h0000);
    observe(3'd7, 4'd1, v);
    check("a_mode7", v, 16'h0000);

    // ADDI r2,1 stream; mid-run reset must discard r1 and the pipeline.
    @(posedge clk);
    #10;
    apply_reset(16'h2081);
    for (int k = 1; k <= 20; k++) begin
      if (k < 6) e = 16'h0000;
`ifdef FORWARDING_EN
      else e = 16'(k - 5);
`else
      else e = 16'((k - 6) / 3 + 1);
`endif
      exp_q.push_back(e);
    end
    for (int k = 1; k <= 20; k++) begin
      tick();
      observe(3'd0, 4'd2, v);
      check($sformatf("b_r2_e%0d", k), v, exp_q.pop_front());
    end

    // ALU program with two-instruction spacing between dependent ops.
    @(posedge clk);
    #10;
    apply_reset(16'hFC00);
    rom[0]  = 16'h3CFF; // LUI  r3,0x3F    r3=FC00
    rom[1]  = 16'h2005; // ADDI r0,5       dropped
    rom[2]  = 16'h343F; // ORI  r0,0x3F    dropped
    rom[3]  = 16'h00CC; // ADD  r3,r3      r3=F800
    rom[4]  = 16'h213F; // ADDI r4,-1      r4=FFFF
    rom[5]  = 16'h356A; // ORI  r5,0x2A    r5=002A
    rom[6]  = 16'h3D95; // LUI  r6,0x15    r6=5400
    rom[7]  = 16'h390F; // XORI r4,0x0F    r4=FFF0
    rom[8]  = 16'hFC00; // NOP
    rom[9]  = 16'h0159; // SUB  r5,r6      r5=AC2A
    rom[10] = 16'h010E; // AND  r4,r3      r4=F800
    rom[11] = 16'h018F; // OR   r6,r3      r6=FC00
    rom[12] = 16'h317C; // ANDI r5,0x3C    r5=0028
    rom[13] = 16'h000C; // ADD  r0,r3      dropped
    rom[14] = 16'h41C1; // unknown opcode, rd=r7

    add_vec(1,  3'd1, 4'd0, 16'h0000);
    add_vec(2,  3'd1, 4'd0, 16'h0001);
    add_vec(2,  3'd2, 4'd0, 16'h3CFF);
    add_vec(3,  3'd2, 4'd0, 16'h2005);
    add_vec(3,  3'd3, 4'd0, 16'hFC00);
    add_vec(5,  3'd4, 4'd0, 16'hFC00);
    add_vec(5,  3'd5, 4'd0, 16'h8003);
    add_vec(6,  3'd0, 4'd3, 16'hFC00);
    add_vec(6,  3'd3, 4'd0, 16'hF800);
    add_vec(8,  3'd0, 4'd3, 16'hFC00);
    add_vec(8,  3'd4, 4'd0, 16'hF800);
    add_vec(8,  3'd5, 4'd0, 16'h8003);
    add_vec(9,  3'd0, 4'd3, 16'hF800);
    add_vec(10, 3'd0, 4'd0, 16'h0000);
    add_vec(14, 3'd4, 4'd0, 16'hAC2A);
    add_vec(14, 3'd5, 4'd0, 16'h8005);
    add_vec(24, 3'd1, 4'd0, 16'h0017);
    add_vec(24, 3'd6, 4'd3, 16'h0000);
    add_vec(24, 3'd7, 4'd3, 16'h0000);
    add_vec(24, 3'd0, 4'd0, 16'h0000);
    add_vec(24, 3'd0, 4'd1, 16'h0000);
    add_vec(24, 3'd0, 4'd2, 16'h0000);
    add_vec(24, 3'd0, 4'd3, 16'hF800);
    add_vec(24, 3'd0, 4'd4, 16'hF800);
    add_vec(24, 3'd0, 4'd5, 16'h0028);
    add_vec(24, 3'd0, 4'd6, 16'hFC00);
    for (int r = 7; r < 16; r++) add_vec(24, 3'd0, r[3:0], 16'h0000);

    for (int k = 1; k <= 24; k++) begin
      tick();
      for (int i = 0; i < vecs.size(); i++) begin
        if (vecs[i].cyc == k) begin
          observe(vecs[i].mode, vecs[i].sel, v);
          check($sformatf("c_vec%0d_e%0d_m%0d_s%0d", i, k, vecs[i].mode, vecs[i].sel), v, vecs[i].exp);
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
